cp0_reg: RTL

//  MIPS CP0 register file: the write target of ALU C0_out (mtc0) and the read source of ALU C0_in (mfc0).

---
 rtl/cp0_reg_pkg.sv | 85 ++++++++
 rtl/cp0_reg_timer.sv | 51 +++++
 rtl/cp0_reg.sv | 98 +++++++++
 3 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register numbers, exception type codes, ExcCode values,
// Status/Cause bit positions, write masks and small decode/merge helpers.
package cp0_reg_pkg;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;

  localparam int STATUS_EXL     = 1;
  localparam int CAUSE_BD       = 31;
  localparam int CAUSE_IP_HW_LO = 10;
  localparam int CAUSE_IP_HW_HI = 15;
  localparam int CAUSE_EXC_LO   = 2;
  localparam int CAUSE_EXC_HI   = 6;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    EXC_KIND_NONE,
    EXC_KIND_TAKE,
    EXC_KIND_RET
  } exc_kind_e;

  typedef struct packed {
    exc_kind_e  kind;
    logic [4:0] code;
    logic       bad_addr;
  } exc_dec_t;

  function automatic exc_dec_t decode_exc(input logic [31:0] t);
    exc_dec_t d;
    d.kind     = EXC_KIND_NONE;
    d.code     = 5'h00;
    d.bad_addr = 1'b0;
    case (t)
      EXC_INT:  begin d.kind = EXC_KIND_TAKE; d.code = EXCCODE_INT; end
      EXC_ADEL: begin d.kind = EXC_KIND_TAKE; d.code = EXCCODE_ADEL; d.bad_addr = 1'b1; end
      EXC_ADES: begin d.kind = EXC_KIND_TAKE; d.code = EXCCODE_ADES; d.bad_addr = 1'b1; end
      EXC_SYS:  begin d.kind = EXC_KIND_TAKE; d.code = EXCCODE_SYS; end
      EXC_BP:   begin d.kind = EXC_KIND_TAKE; d.code = EXCCODE_BP; end
      EXC_RI:   begin d.kind = EXC_KIND_TAKE; d.code = EXCCODE_RI; end
      EXC_OV:   begin d.kind = EXC_KIND_TAKE; d.code = EXCCODE_OV; end
      EXC_ERET: d.kind = EXC_KIND_RET;
      default:  d.kind = EXC_KIND_NONE;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] reg_wmask(input logic [4:0] addr);
    case (addr)
      CP0_REG_STATUS:                             reg_wmask = STATUS_WMASK;
      CP0_REG_CAUSE:                              reg_wmask = CAUSE_WMASK;
      CP0_REG_COUNT, CP0_REG_COMPARE, CP0_REG_EPC: reg_wmask = FULL_WMASK;
      default:                                    reg_wmask = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                        input logic [31:0] mask);
    merge = (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_reg_timer.sv
// Count/Compare timer: clock divider, free-running Count, sticky match interrupt.
// Match interrupt only exists when CP0_TIMER_INT_EN is defined; otherwise timer_int is 0.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div     <= '0;
      count   <= 32'h0;
      compare <= 32'h0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else if (div == DIV_LAST) begin
        count <= count + 32'd1;
        div   <= '0;
      end else begin
        div <= div + 1'b1;
      end
      if (compare_we) compare <= wdata;
    end
  end

`ifdef CP0_TIMER_INT_EN
  // A Compare write acknowledges the interrupt even if the match holds this edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                timer_int <= 1'b0;
    else if (compare_we)                        timer_int <= 1'b0;
    else if (compare != 32'h0 && count == compare) timer_int <= 1'b1;
  end
`else
  assign timer_int = 1'b0;
`endif

endmodule

// File: rtl/cp0_reg.sv
// MIPS CP0 register file (BadVAddr/Count/Compare/Status/Cause/EPC) with exception/eret bookkeeping.
// Define CP0_TIMER_INT_EN to enable the Count==Compare timer interrupt.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] data_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);

  logic [31:0] badvaddr, status, cause, epc, count, compare;
  logic [31:0] rd_val;
  logic [5:0]  ip_hw;
  logic        wr;
  exc_dec_t    exc;

  // Any nonzero excepttype flushes the instruction, so its mtc0 never lands.
  assign exc   = decode_exc(excepttype_i);
  assign wr    = we_i && (excepttype_i == 32'h0);
  assign ip_hw = {int_i[5] | timer_int_o, int_i[4:0]};

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (wr && waddr_i == CP0_REG_COUNT),
    .compare_we (wr && waddr_i == CP0_REG_COMPARE),
    .wdata      (data_i),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int_o)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr <= 32'h0;
      status   <= STATUS_RST;
      cause    <= 32'h0;
      epc      <= 32'h0;
    end else begin
      cause[CAUSE_IP_HW_HI:CAUSE_IP_HW_LO] <= ip_hw;
      if (exc.kind == EXC_KIND_TAKE) begin
        if (!status[STATUS_EXL]) begin
          epc             <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
          cause[CAUSE_BD] <= in_delayslot_i;
        end
        status[STATUS_EXL]              <= 1'b1;
        cause[CAUSE_EXC_HI:CAUSE_EXC_LO] <= exc.code;
        if (exc.bad_addr) badvaddr <= bad_addr_i;
      end else if (exc.kind == EXC_KIND_RET) begin
        status[STATUS_EXL] <= 1'b0;
      end else if (wr) begin
        case (waddr_i)
          CP0_REG_STATUS: status     <= merge(status, data_i, STATUS_WMASK);
          CP0_REG_CAUSE:  cause[9:8] <= data_i[9:8];
          CP0_REG_EPC:    epc        <= data_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = 32'h0;
    case (raddr_i)
      CP0_REG_BADVADDR: rd_val = badvaddr;
      CP0_REG_COUNT:    rd_val = count;
      CP0_REG_COMPARE:  rd_val = compare;
      CP0_REG_STATUS:   rd_val = status;
      CP0_REG_CAUSE:    rd_val = cause;
      CP0_REG_EPC:      rd_val = epc;
      default:          rd_val = 32'h0;
    endcase
  end

  // Same-cycle mtc0 to the read register is forwarded through its write mask.
  assign data_o = (we_i && waddr_i == raddr_i) ? merge(rd_val, data_i, reg_wmask(raddr_i)) : rd_val;

  assign status_o = status;
  assign cause_o  = cause;
  assign epc_o    = epc;

endmodule
